add_sub_seq_ctrl: RTL

- Nibble-serial sequencer for a single shared 4-bit adder/subtractor slice, with inverted-B and carry-in for subtract.
- Performs WIDTH-bit add or subtract by iterating the slice over NIBBLES cycles and chaining carry/borrow between nibbles.
- Trades latency for area; sits between a command source (start/op/operands) and downstream logic that consumes result on done.

---
 rtl/add_sub_seq_ctrl_if.sv | 37 +++
 rtl/add_sub_seq_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/add_sub_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : add_sub_seq_ctrl_if
// Purpose  : Command/result bundle for the nibble-serial add/subtract
//            sequencer.
// Ports    : start, op, a, b      - command from the requester
//            busy, done           - sequencer status
//            result, cbout, ovf   - completed operation outputs
//            master modport = requester side, slave modport = sequencer side.
// Revision : 1.0 - initial release
// ============================================================================
interface add_sub_seq_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int WIDTH = 4 * NIBBLES;

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cbout;
  logic             ovf;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cbout, ovf
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cbout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/add_sub_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : add_sub_seq_ctrl
// Purpose  : Performs a WIDTH-bit add or subtract by iterating one shared
//            4-bit adder slice over NIBBLES cycles, LSB nibble first, with
//            the carry/borrow chained between cycles.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous active-high reset
//            bus  - add_sub_seq_ctrl_if.slave
//                   start/op/a/b sampled in IDLE only
//                   busy high in RUN and DONE, done is a one-cycle pulse
//                   result/cbout/ovf update only when an operation completes
// Revision : 1.0 - initial release
// ============================================================================
module add_sub_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  add_sub_seq_ctrl_if.slave  bus
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_l;
  logic [WIDTH-1:0] b_l;
  logic             op_l;
  logic [WIDTH-1:0] acc;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] result;
  logic             cbout;
  logic             ovf;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       slice_sum;
  logic             c_msb_in;
  logic [WIDTH-1:0] acc_next;

  // Shared slice: subtract is A + ~B + carry, where carry was seeded with op
  // at acceptance, so no separate increment is ever needed.
  always_comb begin
    a_nib     = a_l[{idx, 2'b00} +: 4];
    b_nib     = b_l[{idx, 2'b00} +: 4] ^ {4{op_l}};
    slice_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
    // Carry into bit 3 of the slice recovered from the sum bit:
    // s3 = a3 ^ b3 ^ c3  =>  c3 = s3 ^ a3 ^ b3. On the top nibble this is
    // the carry into the sign bit.
    c_msb_in  = slice_sum[3] ^ a_nib[3] ^ b_nib[3];
    acc_next  = acc;
    acc_next[{idx, 2'b00} +: 4] = slice_sum[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_l    <= '0;
      b_l    <= '0;
      op_l   <= 1'b0;
      acc    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cbout  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_l   <= bus.a;
            b_l   <= bus.b;
            op_l  <= bus.op;
            idx   <= '0;
            carry <= bus.op;
            acc   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc   <= acc_next;
          carry <= slice_sum[4];
          idx   <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            // Only the completing edge touches the visible outputs.
            result <= acc_next;
            cbout  <= slice_sum[4];
            ovf    <= c_msb_in ^ slice_sum[4];
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = (state == ST_RUN) || (state == ST_DONE);
  assign bus.done   = (state == ST_DONE);
  assign bus.result = result;
  assign bus.cbout  = cbout;
  assign bus.ovf    = ovf;

endmodule
`default_nettype wire
